// File: rtl/timer_ctrl_pkg.sv
// Shared constants for timer_ctrl: register offsets, CTRL/STATUS bit indices
// and the FSM state encoding.
package timer_ctrl_pkg;

  // Register window offsets (port_id[2:0])
  localparam logic [2:0] OFF_CMP0     = 3'd0;
  localparam logic [2:0] OFF_CMP1     = 3'd1;
  localparam logic [2:0] OFF_CMP2     = 3'd2;
  localparam logic [2:0] OFF_CMP3     = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_STATUS   = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;
  localparam logic [2:0] OFF_RSVD     = 3'd7;

  // CTRL bit indices
  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_PERIODIC = 2;
  localparam int CTRL_IE       = 3;

  // STATUS bit indices
  localparam int STAT_RUNNING  = 0;
  localparam int STAT_EXPIRED  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Picoblaze I/O port bus plus interrupt pair. master = CPU side,
// slave = peripheral side.
interface timer_ctrl_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt_ack;
  logic       timer_interrupt;

  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, timer_interrupt
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, timer_interrupt
  );
endinterface

// File: rtl/timer_ctrl_core.sv
// Count / compare / prescale datapath. The control block tells it when to
// start, stop and whether the FSM is in RUN; it reports the expiry cycle.
module timer_ctrl_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        run_i,
  input  logic        periodic_i,
  input  logic [31:0] shadow_i,
  input  logic [7:0]  prescale_i,
  output logic        expire_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] active_q, active_d;
  logic [7:0]  presc_q, presc_d;
  logic        tick;
  logic        match;

  // >= keeps ticking sane if PRESCALE is lowered below the running prescale count
  assign tick     = (presc_q >= prescale_i);
  assign match    = (count_q == active_q);
  assign expire_o = run_i && tick && match;

  // Next-state for count, active compare and prescale counter
  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    presc_d  = presc_q;
    if (stop_i) begin
      count_d = '0;
      presc_d = '0;
    end else if (start_i) begin
      count_d  = '0;
      presc_d  = '0;
      active_d = shadow_i;
    end else if (run_i) begin
      if (!tick) begin
        presc_d = presc_q + 8'd1;
      end else begin
        presc_d = '0;
        if (match) begin
          count_d = '0;
          if (periodic_i) active_d = shadow_i;
        end else begin
          count_d = count_q + 32'd1;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= '0;
      presc_q  <= '0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      presc_q  <= presc_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Picoblaze-attached 32-bit timer: register decode, IDLE/RUN FSM, EXPIRED
// flag and registered interrupt. Datapath lives in timer_ctrl_core.
// Optional feature macro: TIMER_CTRL_PRESCALE_EN (R/W PRESCALE at offset 6).
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic         clk,
  input  logic         reset,
  timer_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] shadow_q;
  logic        periodic_q, ie_q, expired_q, irq_q;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  prescale_v;

  logic       sel, wr;
  logic [2:0] off;
  logic       ctrl_wr, start_p, stop_p, w1c, expire, running;

  assign sel     = ((bus.port_id & 8'hF8) == BASE_ADDR);
  assign off     = bus.port_id[2:0];
  assign wr      = bus.write_strobe && sel;
  assign ctrl_wr = wr && (off == OFF_CTRL);
  // STOP beats START when both are set in one write
  assign stop_p  = ctrl_wr && bus.out_port[CTRL_STOP];
  assign start_p = ctrl_wr && bus.out_port[CTRL_START] && !bus.out_port[CTRL_STOP];
  assign w1c     = wr && (off == OFF_STATUS) && bus.out_port[STAT_EXPIRED];
  assign running = (state_q == ST_RUN);

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0] prescale_q;

  // PRESCALE register
  always_ff @(posedge clk) begin
    if (reset)                           prescale_q <= '0;
    else if (wr && off == OFF_PRESCALE)  prescale_q <= bus.out_port;
  end
  assign prescale_v = prescale_q;
`else
  // No prescaler: every clk in RUN is a tick, offset 6 is read-as-zero
  assign prescale_v = 8'd0;
`endif

  timer_ctrl_core u_core (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_p),
    .stop_i     (stop_p),
    .run_i      (running),
    .periodic_i (periodic_q),
    .shadow_i   (shadow_q),
    .prescale_i (prescale_v),
    .expire_o   (expire)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: STOP, then START (restart allowed in RUN), then one-shot expiry
  always_comb begin
    state_d = state_q;
    if (stop_p)                       state_d = ST_IDLE;
    else if (start_p)                 state_d = ST_RUN;
    else if (expire && !periodic_q)   state_d = ST_IDLE;
  end

  // Shadow compare bytes, little-endian
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
    end else if (wr) begin
      case (off)
        OFF_CMP0: shadow_q[7:0]   <= bus.out_port;
        OFF_CMP1: shadow_q[15:8]  <= bus.out_port;
        OFF_CMP2: shadow_q[23:16] <= bus.out_port;
        OFF_CMP3: shadow_q[31:24] <= bus.out_port;
        default:  ;
      endcase
    end
  end

  // Held CTRL bits
  always_ff @(posedge clk) begin
    if (reset) begin
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
    end else if (ctrl_wr) begin
      periodic_q <= bus.out_port[CTRL_PERIODIC];
      ie_q       <= bus.out_port[CTRL_IE];
    end
  end

  // EXPIRED flag: set has priority over ack / W1C clear
  always_ff @(posedge clk) begin
    if (reset)                           expired_q <= 1'b0;
    else if (expire)                     expired_q <= 1'b1;
    else if (bus.interrupt_ack || w1c)   expired_q <= 1'b0;
  end

  // Registered interrupt request
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= expired_q && ie_q;
  end

  // Read mux, zero outside the window
  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (off)
        OFF_CMP0:     rdata_d = shadow_q[7:0];
        OFF_CMP1:     rdata_d = shadow_q[15:8];
        OFF_CMP2:     rdata_d = shadow_q[23:16];
        OFF_CMP3:     rdata_d = shadow_q[31:24];
        OFF_CTRL:     rdata_d = {4'b0, ie_q, periodic_q, 2'b0};
        OFF_STATUS:   rdata_d = {6'b0, expired_q, running};
        OFF_PRESCALE: rdata_d = prescale_v;
        default:      rdata_d = '0;
      endcase
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign bus.in_port         = rdata_q;
  assign bus.timer_interrupt = irq_q;

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 8'h10, SHALL be the base port_id of the 8-entry register window (BASE_ADDR[2:0] = 0).
REQ-002 clk  input  1  SHALL be the single clock for all state.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 port_id  input  8  SHALL be the Picoblaze port address.
REQ-005 write_strobe  input  1  SHALL qualify out_port as a write to port_id.
REQ-006 read_strobe  input  1  SHALL mark a read of port_id (read side effects only).
REQ-007 out_port  input  8  SHALL be the Picoblaze write data.
REQ-008 in_port  output  8  SHALL be the registered read data.
REQ-009 interrupt_ack  input  1  SHALL be the Picoblaze interrupt acknowledge.
REQ-010 timer_interrupt  output  1  SHALL be the registered interrupt request.

Function
REQ-011 Register map at BASE_ADDR+offset SHALL be: 0-3 CMP shadow bytes (little-endian, R/W); 4 CTRL; 5 STATUS; 6 PRESCALE (see Configuration); 7 reserved (reads 0, writes ignored).
REQ-012 CTRL write SHALL decode: bit0 START (pulse), bit1 STOP (pulse), bit2 PERIODIC (held), bit3 IE (held); a CTRL read SHALL return {4'b0, IE, PERIODIC, 2'b0}.
REQ-013 STATUS read SHALL return {6'b0, EXPIRED, RUNNING}; a STATUS write with bit1=1 SHALL clear EXPIRED (W1C); bit0 writes are ignored.
REQ-014 in_port SHALL update one clk after port_id selects a window address and SHALL be 0 for addresses outside the window.
REQ-015 FSM states SHALL be IDLE and RUN; RUNNING = (state == RUN).
REQ-016 START SHALL copy the 32-bit shadow CMP into the active compare, clear count to 0, and enter RUN on the next clk, from either state (restart in RUN).
REQ-017 STOP SHALL force IDLE on the next clk with count cleared; STOP and START in the same write: STOP wins.
REQ-018 In RUN, count SHALL increment by 1 per tick; the expiry cycle SHALL be count == active compare, so the period is compare+1 ticks (compare 0 = expiry every tick).
REQ-019 On expiry, EXPIRED SHALL set. If PERIODIC=1, count SHALL return to 0, the active compare SHALL reload from shadow, and the FSM SHALL stay in RUN. If PERIODIC=0, the FSM SHALL go to IDLE.
REQ-020 Shadow CMP writes during RUN SHALL NOT affect the active compare until the next START or periodic reload.
REQ-021 timer_interrupt SHALL be registered EXPIRED & IE, asserting one clk after EXPIRED sets.
REQ-022 interrupt_ack SHALL clear EXPIRED. If expiry coincides with ack or a W1C clear, set SHALL win.
REQ-023 count SHALL be 32-bit unsigned and never wraps, because expiry occurs at or before 32'hFFFF_FFFF.

Reset
REQ-024 Reset SHALL force IDLE, count=0, active and shadow CMP=0, PERIODIC=IE=EXPIRED=0, PRESCALE=0, in_port=0 and timer_interrupt=0.
REQ-025 Reset asserted mid-RUN SHALL take priority over all register writes and expiry in that cycle.

Configuration
REQ-026 With TIMER_CTRL_PRESCALE_EN defined, offset 6 SHALL be an R/W 8-bit PRESCALE register. A tick SHALL occur once every PRESCALE+1 clks in RUN, and the prescale counter SHALL clear on START, STOP and expiry.
REQ-027 Without TIMER_CTRL_PRESCALE_EN, every clk in RUN SHALL be a tick, offset 6 SHALL read 0, and writes to offset 6 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the register offset constants, CTRL/STATUS bit-index constants and the FSM state encoding.
REQ-029 The count/compare/prescale datapath SHALL be a sub-module timer_ctrl_core; register decode, FSM control and interrupt logic SHALL stay in timer_ctrl.

Verification
REQ-030 The bench SHALL cover: CMP=5, CTRL=0x09 (START|IE, one-shot) -> EXPIRED set and RUNNING cleared 6 clks after START takes effect, timer_interrupt high 1 clk later.
REQ-031 The bench SHALL cover: CMP=3, CTRL=0x0D (periodic) -> EXPIRED every 4 clks; interrupt_ack between expiries drops timer_interrupt, which reasserts on the next expiry.
REQ-032 The bench SHALL cover: STATUS W1C or interrupt_ack in the exact expiry cycle -> EXPIRED remains 1.
REQ-033 The bench SHALL cover: periodic with CMP=10, shadow rewritten to 2 mid-period -> current period stays 11 clks, then subsequent periods are 3 clks.
REQ-034 The bench SHALL cover: CTRL=0x03 (START|STOP) -> RUNNING stays 0; reset asserted mid-RUN -> all outputs and registers at reset values next clk.
REQ-035 The bench SHALL cover, with TIMER_CTRL_PRESCALE_EN defined: PRESCALE=3, CMP=1, one-shot -> expiry 8 clks after START; without the macro, offset 6 reads 0.
